lsu_axi_ld_engine: RTL and testbench
====================================

Name: lsu_axi_ld_engine

Overview:
- Parametrised successor to the LSU's single-burst AXI read path.
- Takes one load command from the IDU side and issues a train of AXI read bursts with a programmable row pitch.
- Keeps up to MAX_OUT bursts outstanding and streams every returned beat into the IRAM or WRAM write port.
- Sits between the LSU command decode and the AXI read channel; replaces fixed-width, one-burst-at-a-time loading.

Parameters:
- DATA_W, 64, AXI read data and SRAM write data width in bits.
- ADDR_W, 31, DRAM byte-address width.
- SRAM_AW, 12, IRAM/WRAM word-address width.
- ID_W, 8, AXI ARID/RID width.
- MAX_OUT, 4, maximum outstanding read bursts (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_vld  in  1  load command valid
- cmd_rdy  out  1  engine idle, command accepted on cmd_vld&cmd_rdy
- cmd_tgt_wram  in  1  0=IRAM, 1=WRAM
- cmd_dram_addr  in  ADDR_W  first burst byte address
- cmd_pitch  in  ADDR_W  byte offset between consecutive bursts
- cmd_num  in  8  burst count minus 1
- cmd_len  in  8  beats per burst minus 1 (AXI arlen)
- cmd_sram_addr  in  SRAM_AW  first SRAM word address
- lsu_axi_arvld  out  1  AR valid
- axi_lsu_arrdy  in  1  AR ready
- lsu_axi_araddr  out  ADDR_W  burst address
- lsu_axi_arlen  out  8  equals latched cmd_len
- lsu_axi_arsize  out  3  log2(DATA_W/8)
- lsu_axi_arburst  out  2  fixed 2'b01 (INCR)
- lsu_axi_arid  out  ID_W  burst index, low ID_W bits
- axi_lsu_rvld  in  1  R valid
- lsu_axi_rrdy  out  1  R ready
- axi_lsu_rdata  in  DATA_W  read data
- axi_lsu_rresp  in  2  read response
- axi_lsu_rlast  in  1  last beat of burst
- sram_iram_wen  out  1  IRAM write enable
- sram_wram_wen  out  1  WRAM write enable
- sram_waddr  out  SRAM_AW  SRAM write address
- sram_wdata  out  DATA_W  SRAM write data
- ld_done  out  1  one-cycle completion pulse
- ld_err  out  1  sticky error flag, valid with ld_done

Behaviour:
- Reset: all outputs 0 except lsu_axi_arsize/arburst (constants) and cmd_rdy=1; state=IDLE; all counters 0.
- Reset mid-operation aborts the command and returns to IDLE. Beats arriving afterwards are not accepted because rrdy=0.
- FSM states:
  - IDLE: cmd_rdy=1. On accept, latch all cmd_* fields, clear ld_err, go to ISSUE.
  - ISSUE: issue AR bursts.
    - arvld=1 while issued_cnt<=cmd_num and outstanding<MAX_OUT.
    - araddr = cmd_dram_addr + issued_cnt*cmd_pitch, mod 2^ADDR_W, kept as a running-sum register (no multiplier).
    - AR fields hold stable while arvld&!arrdy.
    - After the handshake for burst cmd_num, go to DRAIN.
  - DRAIN: wait until rcv_burst_cnt==cmd_num+1, then go to DONE.
  - DONE: ld_done=1 for exactly one cycle, then IDLE. cmd_rdy=0 in DONE.
- Outstanding counter:
  - +1 on AR handshake, -1 on R handshake with rlast. Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUT.
- R channel:
  - rrdy=1 in ISSUE/DRAIN when outstanding>0 (no SRAM backpressure).
  - Responses return in AR order; RID is not checked.
- SRAM write:
  - Each R handshake writes rdata to sram_waddr in the same cycle (combinational wen = rvld&rrdy, gated by the target flag).
  - sram_waddr starts at cmd_sram_addr, increments by 1 per beat and wraps modulo 2^SRAM_AW.
  - The beat with rlast increments rcv_burst_cnt.
- Error: rresp!=2'b00 on any accepted beat sets ld_err. The data is still written. ld_err holds until the next command is accepted.
- Latency: first arvld occurs 1 cycle after command accept. ld_done occurs 1 cycle after the final rlast handshake.
- Total beats = (cmd_num+1)*(cmd_len+1), at most 65536.

Test Plan:
- Basic load: cmd_num=0, cmd_len=3, addr=0x100, sram_addr=0x010, target IRAM, zero-wait slave -> one AR with araddr=0x100, arlen=3; IRAM writes at 0x010..0x013; ld_done 1 cycle after rlast; ld_err=0.
- Pitched multi-burst: cmd_num=3, cmd_len=1, addr=0x1000, pitch=0x200, target WRAM -> araddr sequence 0x1000, 0x1200, 0x1400, 0x1600; arid 0..3; 8 WRAM writes at consecutive addresses.
- Outstanding limit: MAX_OUT=4, cmd_num=7, slave delays all R data by 50 cycles -> exactly 4 AR handshakes, then arvld=0 until the first rlast; then one new AR is issued per completed burst.
- SRAM wrap: sram_addr=0xFFE, cmd_len=3 -> writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Error response: beat 2 of 4 returns rresp=2'b10 -> all 4 beats written; ld_err=1 at ld_done; the next accepted command clears ld_err.
- Reset mid-op: assert rst for 1 cycle after 2 of 4 ARs -> next cycle cmd_rdy=1, arvld=0, rrdy=0, no ld_done; a new command then executes normally.

Source files
------------

// File: rtl/lsu_axi_ld_engine.sv
// Pitched multi-burst AXI read engine: streams one load command as a train of
// INCR bursts into the IRAM/WRAM write port with up to MAX_OUT bursts in flight.
module lsu_axi_ld_engine #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 31,
    parameter int SRAM_AW = 12,
    parameter int ID_W    = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_tgt_wram,
    input  logic [ADDR_W-1:0]   cmd_dram_addr,
    input  logic [ADDR_W-1:0]   cmd_pitch,
    input  logic [7:0]          cmd_num,
    input  logic [7:0]          cmd_len,
    input  logic [SRAM_AW-1:0]  cmd_sram_addr,
    output logic                lsu_axi_arvld,
    input  logic                axi_lsu_arrdy,
    output logic [ADDR_W-1:0]   lsu_axi_araddr,
    output logic [7:0]          lsu_axi_arlen,
    output logic [2:0]          lsu_axi_arsize,
    output logic [1:0]          lsu_axi_arburst,
    output logic [ID_W-1:0]     lsu_axi_arid,
    input  logic                axi_lsu_rvld,
    output logic                lsu_axi_rrdy,
    input  logic [DATA_W-1:0]   axi_lsu_rdata,
    input  logic [1:0]          axi_lsu_rresp,
    input  logic                axi_lsu_rlast,
    output logic                sram_iram_wen,
    output logic                sram_wram_wen,
    output logic [SRAM_AW-1:0]  sram_waddr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                ld_done,
    output logic                ld_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               tgt_wram;
    logic [ADDR_W-1:0]  pitch;
    logic [ADDR_W-1:0]  araddr_q;
    logic [7:0]         num;
    logic [7:0]         len;
    logic [8:0]         issued_cnt;
    logic [8:0]         rcv_burst_cnt;
    logic [8:0]         rcv_nxt;
    logic [3:0]         outstanding;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic               err_q;
    logic               cmd_acc;
    logic               ar_hs;
    logic               r_hs;
    logic               r_last_hs;

    assign cmd_rdy   = (state == IDLE);
    assign cmd_acc   = cmd_vld & cmd_rdy;

    assign lsu_axi_arvld   = (state == ISSUE) && (issued_cnt <= {1'b0, num}) &&
                             (outstanding < MAX_OUT_C);
    assign ar_hs           = lsu_axi_arvld & axi_lsu_arrdy;
    assign lsu_axi_araddr  = araddr_q;
    assign lsu_axi_arlen   = len;
    assign lsu_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign lsu_axi_arburst = 2'b01;
    assign lsu_axi_arid    = ID_W'(issued_cnt);

    // No SRAM backpressure: R is accepted whenever a burst is in flight.
    assign lsu_axi_rrdy = ((state == ISSUE) || (state == DRAIN)) && (outstanding != 4'd0);
    assign r_hs         = axi_lsu_rvld & lsu_axi_rrdy;
    assign r_last_hs    = r_hs & axi_lsu_rlast;
    assign rcv_nxt      = rcv_burst_cnt + {8'd0, r_last_hs};

    assign sram_iram_wen = r_hs & ~tgt_wram;
    assign sram_wram_wen = r_hs & tgt_wram;
    assign sram_waddr    = sram_addr_q;
    assign sram_wdata    = r_hs ? axi_lsu_rdata : '0;

    assign ld_done = (state == DONE);
    assign ld_err  = err_q;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_acc) state_nxt = ISSUE;
            ISSUE:   if (ar_hs && (issued_cnt == {1'b0, num})) state_nxt = DRAIN;
            // Look at the incoming rlast so ld_done follows the final beat by one cycle.
            DRAIN:   if (rcv_nxt == ({1'b0, num} + 9'd1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (rst) begin
            state         <= IDLE;
            tgt_wram      <= 1'b0;
            pitch         <= '0;
            araddr_q      <= '0;
            num           <= '0;
            len           <= '0;
            issued_cnt    <= '0;
            rcv_burst_cnt <= '0;
            outstanding   <= '0;
            sram_addr_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                tgt_wram      <= cmd_tgt_wram;
                pitch         <= cmd_pitch;
                araddr_q      <= cmd_dram_addr;
                num           <= cmd_num;
                len           <= cmd_len;
                issued_cnt    <= '0;
                rcv_burst_cnt <= '0;
                outstanding   <= '0;
                sram_addr_q   <= cmd_sram_addr;
                err_q         <= 1'b0;
            end else begin
                // Running sum replaces base + index*pitch.
                if (ar_hs) begin
                    araddr_q   <= araddr_q + pitch;
                    issued_cnt <= issued_cnt + 9'd1;
                end
                outstanding   <= outstanding + {3'd0, ar_hs} - {3'd0, r_last_hs};
                rcv_burst_cnt <= rcv_nxt;
                if (r_hs) begin
                    sram_addr_q <= sram_addr_q + 1'b1;
                    if (axi_lsu_rresp != 2'b00) err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_ld_engine.sv
// Self-checking bench for lsu_axi_ld_engine: randomized AXI slave plus a
// transaction-level reference model of the expected AR train and SRAM writes.
module tb_lsu_axi_ld_engine;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 31;
    localparam int SRAM_AW = 12;
    localparam int ID_W    = 8;
    localparam int MAX_OUT = 4;

    logic                clk;
    logic                rst;
    logic                cmd_vld;
    logic                cmd_rdy;
    logic                cmd_tgt_wram;
    logic [ADDR_W-1:0]   cmd_dram_addr;
    logic [ADDR_W-1:0]   cmd_pitch;
    logic [7:0]          cmd_num;
    logic [7:0]          cmd_len;
    logic [SRAM_AW-1:0]  cmd_sram_addr;
    logic                arvld;
    logic                arrdy;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [ID_W-1:0]     arid;
    logic                rvld;
    logic                rrdy;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                iram_wen;
    logic                wram_wen;
    logic [SRAM_AW-1:0]  waddr;
    logic [DATA_W-1:0]   wdata;
    logic                ld_done;
    logic                ld_err;

    lsu_axi_ld_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .ID_W(ID_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_tgt_wram(cmd_tgt_wram),
        .cmd_dram_addr(cmd_dram_addr), .cmd_pitch(cmd_pitch), .cmd_num(cmd_num),
        .cmd_len(cmd_len), .cmd_sram_addr(cmd_sram_addr),
        .lsu_axi_arvld(arvld), .axi_lsu_arrdy(arrdy), .lsu_axi_araddr(araddr),
        .lsu_axi_arlen(arlen), .lsu_axi_arsize(arsize), .lsu_axi_arburst(arburst),
        .lsu_axi_arid(arid),
        .axi_lsu_rvld(rvld), .lsu_axi_rrdy(rrdy), .axi_lsu_rdata(rdata),
        .axi_lsu_rresp(rresp), .axi_lsu_rlast(rlast),
        .sram_iram_wen(iram_wen), .sram_wram_wen(wram_wen), .sram_waddr(waddr),
        .sram_wdata(wdata), .ld_done(ld_done), .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Slave behaviour knobs
    int arrdy_pct = 100;
    int rv_pct    = 100;
    int rdelay    = 0;
    int err_beat  = -1;
    int err_pct   = 0;

    typedef struct {
        int len;
        int rdy;
    } burst_t;
    burst_t pend[$];
    int     bib = 0;
    int     model_out = 0;

    // Observation logs for the current command
    logic [ADDR_W-1:0]  ar_addr_q[$];
    logic [ID_W-1:0]    ar_id_q[$];
    logic [7:0]         ar_len_q[$];
    logic [SRAM_AW-1:0] wr_addr_q[$];
    logic [DATA_W-1:0]  wr_data_q[$];
    logic [1:0]         wr_en_q[$];
    logic [DATA_W-1:0]  rd_q[$];
    bit   err_sent = 0;
    bit   saw_rlast = 0;
    logic err_at_done = 1'b0;
    int   last_rlast_cyc = -2;
    int   done_cyc = -1;
    int   done_cnt = 0;
    int   acc_cyc = -10;
    int   first_ar_cyc = -1;
    int   max_out = 0;
    int   out_viol = 0;
    int   ar_at_first_rlast = -1;

    // Monitor samples at negedge; slave drives #1 after posedge.
    initial begin
        arrdy = 1'b0; rvld = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                pend.delete();
                bib = 0;
                model_out = 0;
            end else begin
                if (cmd_vld && cmd_rdy) acc_cyc = cycle;
                if (arvld && first_ar_cyc < 0) first_ar_cyc = cycle;
                if (arvld && model_out >= MAX_OUT) out_viol++;
                if (arvld && arrdy) begin
                    burst_t b;
                    ar_addr_q.push_back(araddr);
                    ar_id_q.push_back(arid);
                    ar_len_q.push_back(arlen);
                    b.len = int'(arlen);
                    b.rdy = cycle + rdelay;
                    pend.push_back(b);
                    model_out++;
                end
                if (iram_wen || wram_wen) begin
                    wr_addr_q.push_back(waddr);
                    wr_data_q.push_back(wdata);
                    wr_en_q.push_back({wram_wen, iram_wen});
                end
                if (rvld && rrdy) begin
                    rd_q.push_back(rdata);
                    if (rresp != 2'b00) err_sent = 1;
                    if (rlast) begin
                        void'(pend.pop_front());
                        bib = 0;
                        model_out--;
                        last_rlast_cyc = cycle;
                        if (!saw_rlast) begin
                            saw_rlast = 1;
                            ar_at_first_rlast = ar_addr_q.size();
                        end
                    end else begin
                        bib++;
                    end
                end
                if (model_out > max_out) max_out = model_out;
                if (ld_done) begin
                    done_cnt++;
                    done_cyc = cycle;
                    err_at_done = ld_err;
                end
            end
            @(posedge clk);
            #1;
            arrdy = ($urandom_range(0, 99) < arrdy_pct);
            if (pend.size() > 0 && cycle >= pend[0].rdy && $urandom_range(0, 99) < rv_pct) begin
                rvld  = 1'b1;
                rdata = {$urandom, $urandom};
                rlast = (bib == pend[0].len);
                rresp = (rd_q.size() == err_beat || $urandom_range(0, 99) < err_pct) ? 2'b10 : 2'b00;
            end else begin
                rvld  = 1'b0;
                rlast = 1'b0;
                rresp = 2'b00;
            end
        end
    end

    task automatic clear_logs();
        ar_addr_q.delete(); ar_id_q.delete(); ar_len_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_en_q.delete(); rd_q.delete();
        err_sent = 0; saw_rlast = 0; err_at_done = 1'b0;
        last_rlast_cyc = -2; done_cyc = -1; done_cnt = 0; acc_cyc = -10;
        first_ar_cyc = -1; max_out = 0; out_viol = 0; ar_at_first_rlast = -1;
    endtask

    task automatic start_cmd(input bit tgt, input logic [ADDR_W-1:0] addr,
                             input logic [ADDR_W-1:0] pitch, input logic [7:0] num,
                             input logic [7:0] len, input logic [SRAM_AW-1:0] sa);
        @(posedge clk);
        #1;
        clear_logs();
        cmd_vld = 1'b1; cmd_tgt_wram = tgt; cmd_dram_addr = addr; cmd_pitch = pitch;
        cmd_num = num; cmd_len = len; cmd_sram_addr = sa;
        @(posedge clk);
        #1;
        // Scramble the fields after accept to prove they were latched.
        cmd_vld = 1'b0; cmd_tgt_wram = ~tgt; cmd_dram_addr = ADDR_W'($urandom);
        cmd_pitch = ADDR_W'($urandom); cmd_num = 8'($urandom); cmd_len = 8'($urandom);
        cmd_sram_addr = SRAM_AW'($urandom);
    endtask

    // Runs one command to completion and scores it against the transaction model.
    task automatic run_and_score(input string name, input bit tgt, input logic [ADDR_W-1:0] addr,
                                 input logic [ADDR_W-1:0] pitch, input logic [7:0] num,
                                 input logic [7:0] len, input logic [SRAM_AW-1:0] sa);
        int total;
        int bad;
        start_cmd(tgt, addr, pitch, num, len, sa);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total = (int'(num) + 1) * (int'(len) + 1);

        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (ar_addr_q.size() != int'(num) + 1) begin
            errors++; $display("FAIL %s ar_count: got %0d expected %0d", name, ar_addr_q.size(), int'(num) + 1);
        end
        bad = 0;
        for (int i = 0; i < ar_addr_q.size(); i++) begin
            logic [ADDR_W-1:0] ea;
            ea = addr + ADDR_W'(i) * pitch;
            if (ar_addr_q[i] !== ea || ar_id_q[i] !== ID_W'(i) || ar_len_q[i] !== len) begin
                if (bad == 0)
                    $display("FAIL %s ar[%0d]: got addr=%h id=%0d len=%0d expected addr=%h id=%0d len=%0d",
                             name, i, ar_addr_q[i], ar_id_q[i], ar_len_q[i], ea, i % (1 << ID_W), len);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (wr_addr_q.size() != total) begin
            errors++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), total);
        end
        bad = 0;
        for (int k = 0; k < wr_addr_q.size() && k < rd_q.size(); k++) begin
            logic [SRAM_AW-1:0] ew;
            ew = sa + SRAM_AW'(k);
            if (wr_addr_q[k] !== ew || wr_data_q[k] !== rd_q[k] || wr_en_q[k] !== (tgt ? 2'b10 : 2'b01)) begin
                if (bad == 0)
                    $display("FAIL %s write[%0d]: got addr=%h data=%h en=%b expected addr=%h data=%h en=%b",
                             name, k, wr_addr_q[k], wr_data_q[k], wr_en_q[k], ew, rd_q[k], tgt ? 2'b10 : 2'b01);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (err_at_done !== err_sent) begin
            errors++; $display("FAIL %s ld_err: got %b expected %b", name, err_at_done, err_sent);
        end
        checks++;
        if (done_cyc != last_rlast_cyc + 1) begin
            errors++; $display("FAIL %s done_latency: got cycle %0d expected %0d", name, done_cyc, last_rlast_cyc + 1);
        end
        checks++;
        if (first_ar_cyc != acc_cyc + 1) begin
            errors++; $display("FAIL %s ar_latency: got cycle %0d expected %0d", name, first_ar_cyc, acc_cyc + 1);
        end
        checks++;
        if (out_viol != 0 || max_out > MAX_OUT) begin
            errors++; $display("FAIL %s outstanding: got max=%0d viol=%0d expected max<=%0d viol=0",
                               name, max_out, out_viol, MAX_OUT);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || arvld !== 1'b0 || rrdy !== 1'b0 || iram_wen !== 1'b0 ||
            wram_wen !== 1'b0 || ld_done !== 1'b0 || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b arvld=%b rrdy=%b wen=%b%b done=%b err=%b expected 1000000",
                     cmd_rdy, arvld, rrdy, wram_wen, iram_wen, ld_done, ld_err);
        end
        checks++;
        if (araddr !== '0 || arlen !== 8'd0 || arid !== '0 || waddr !== '0 || wdata !== '0 ||
            arsize !== 3'd3 || arburst !== 2'b01) begin
            errors++;
            $display("FAIL reset_fields: got addr=%h len=%h id=%h waddr=%h wdata=%h size=%0d burst=%b expected zeros size=3 burst=01",
                     araddr, arlen, arid, waddr, wdata, arsize, arburst);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || arvld !== 1'b0) begin
            errors++; $display("FAIL reset_release: got rdy=%b arvld=%b expected 1 0", cmd_rdy, arvld);
        end
    endtask

    task automatic test_basic();
        arrdy_pct = 100; rv_pct = 100; rdelay = 0; err_beat = -1; err_pct = 0;
        run_and_score("basic", 1'b0, 31'h100, 31'h0, 8'd0, 8'd3, 12'h010);
        checks++;
        if (ar_addr_q.size() < 1 || ar_addr_q[0] !== 31'h100 || wr_addr_q.size() < 4 ||
            wr_addr_q[0] !== 12'h010 || wr_addr_q[3] !== 12'h013) begin
            errors++; $display("FAIL basic_addrs: got ar=%0d writes=%0d expected ar0=100 w0=010 w3=013",
                               ar_addr_q.size(), wr_addr_q.size());
        end
    endtask

    task automatic test_pitched();
        run_and_score("pitched", 1'b1, 31'h1000, 31'h200, 8'd3, 8'd1, 12'h300);
        checks++;
        if (ar_addr_q.size() != 4 || ar_addr_q[3] !== 31'h1600 || ar_id_q[3] !== 8'd3) begin
            errors++; $display("FAIL pitched_last_ar: got count=%0d expected addr=1600 id=3", ar_addr_q.size());
        end
    endtask

    task automatic test_outstanding();
        rdelay = 50;
        run_and_score("outstanding", 1'b0, 31'h2000, 31'h40, 8'd7, 8'd1, 12'h100);
        rdelay = 0;
        checks++;
        if (ar_at_first_rlast != MAX_OUT) begin
            errors++; $display("FAIL outstanding_before_rlast: got %0d expected %0d", ar_at_first_rlast, MAX_OUT);
        end
        checks++;
        if (max_out != MAX_OUT) begin
            errors++; $display("FAIL outstanding_peak: got %0d expected %0d", max_out, MAX_OUT);
        end
    endtask

    task automatic test_sram_wrap();
        run_and_score("wrap", 1'b1, 31'h7FFF_FFF0, 31'h0, 8'd0, 8'd3, 12'hFFE);
        checks++;
        if (wr_addr_q.size() != 4 || wr_addr_q[1] !== 12'hFFF || wr_addr_q[2] !== 12'h000 ||
            wr_addr_q[3] !== 12'h001) begin
            errors++; $display("FAIL wrap_addrs: got count=%0d expected FFE FFF 000 001", wr_addr_q.size());
        end
    endtask

    task automatic test_error();
        err_beat = 2;
        run_and_score("error", 1'b0, 31'h500, 31'h0, 8'd0, 8'd3, 12'h020);
        err_beat = -1;
        checks++;
        if (err_at_done !== 1'b1 || ld_err !== 1'b1) begin
            errors++; $display("FAIL error_sticky: got at_done=%b idle=%b expected 1 1", err_at_done, ld_err);
        end
        run_and_score("error_clear", 1'b0, 31'h600, 31'h0, 8'd0, 8'd3, 12'h030);
        checks++;
        if (ld_err !== 1'b0) begin
            errors++; $display("FAIL error_cleared: got %b expected 0", ld_err);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        arrdy_pct = 40; rdelay = 40;
        start_cmd(1'b0, 31'h3000, 31'h100, 8'd3, 8'd3, 12'h040);
        n = 0;
        while (ar_addr_q.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ar_addr_q.size() < 2) begin
            errors++; $display("FAIL midop_issue_timeout: got %0d ARs expected >=2", ar_addr_q.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || arvld !== 1'b0 || rrdy !== 1'b0 || ld_done !== 1'b0) begin
            errors++; $display("FAIL midop_after_reset: got rdy=%b arvld=%b rrdy=%b done=%b expected 1 0 0 0",
                               cmd_rdy, arvld, rrdy, ld_done);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt != 0 || wr_addr_q.size() != 0) begin
            errors++; $display("FAIL midop_quiet: got done=%0d writes=%0d expected 0 0", done_cnt, wr_addr_q.size());
        end
        arrdy_pct = 100; rdelay = 0;
        run_and_score("after_reset", 1'b1, 31'h4000, 31'h80, 8'd1, 8'd2, 12'h050);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            arrdy_pct = $urandom_range(20, 100);
            rv_pct    = $urandom_range(50, 100);
            rdelay    = $urandom_range(0, 8);
            err_pct   = ($urandom_range(0, 3) == 0) ? 15 : 0;
            run_and_score($sformatf("random%0d", t), 1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
                          8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), SRAM_AW'($urandom));
        end
        arrdy_pct = 100; rv_pct = 100; rdelay = 0; err_pct = 0;
    endtask

    task automatic test_back_to_back();
        run_and_score("b2b_a", 1'b0, 31'h7000, 31'h10, 8'd2, 8'd0, 12'h200);
        run_and_score("b2b_b", 1'b1, 31'h7100, 31'h20, 8'd4, 8'd1, 12'h210);
    endtask

    initial begin
        rst = 1'b1;
        cmd_vld = 1'b0; cmd_tgt_wram = 1'b0; cmd_dram_addr = '0; cmd_pitch = '0;
        cmd_num = '0; cmd_len = '0; cmd_sram_addr = '0;
        test_reset();
        test_basic();
        test_pitched();
        test_outstanding();
        test_sram_wrap();
        test_error();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
